sprite_blit_ctrl: RTL
=====================

Name: sprite_blit_ctrl

Overview:
- Downstream pixel sequencer for the battle/title screens. It consumes a latched start point and a sprite memory select, and walks a W x H box (or the whole 160x120 screen in clear mode).
- Drives the sprite ROM address and memory select into the colour mux, and takes the muxed colour back.
- Emits registered plot/x/y/colour strobes to the VGA adapter.
- Replaces ad-hoc xCountUp/yCountUp sequencing with one self-contained FSM that has a fixed pipeline latency.

Parameters:
- SPR_W, 40, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- SCR_W, 160, screen width; pixels with x >= SCR_W are clipped
- SCR_H, 120, screen height; pixels with y >= SCR_H are clipped
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= SCR_W*SCR_H

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- clear  in  1  sampled with start; 1 = full-screen black fill
- abort  in  1  synchronous cancel of the current draw
- x0  in  8  start x (xInit)
- y0  in  7  start y (yInit)
- sprite_sel  in  5  memory select to forward
- colour_in  in  3  colour from the colour mux; valid 1 cycle after addr
- mem_sel  out  5  latched sprite_sel, drives the colour mux
- addr  out  ADDR_W  sprite ROM address, row-major: row*SPR_W+col
- x_out  out  8  pixel x to VGA
- y_out  out  7  pixel y to VGA
- colour_out  out  3  pixel colour to VGA
- plot  out  1  VGA write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last plot

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0: mem_sel, addr, x_out, y_out, colour_out, plot, busy, done. Pipeline valid bits cleared. Asserting reset mid-draw abandons the draw with no done pulse.
- States: IDLE, DRAW, FLUSH1, FLUSH2, DONE.
- IDLE:
  - On a clk edge with start=1, latch x0, y0, sprite_sel and clear.
  - Set col=0, row=0, addr=0, busy=1, go to DRAW.
  - Box is SPR_W x SPR_H, or SCR_W x SCR_H with origin forced to (0,0) when clear=1.
- DRAW: one pixel issued per cycle.
  - addr increments by 1.
  - col wraps to 0 at width-1 and row increments.
  - The edge that issues the final pixel (col=width-1, row=height-1) moves to FLUSH1.
- Pipeline, fixed 2-cycle latency:
  - Pixel (col,row) on addr in cycle t.
  - colour_in valid in cycle t+1.
  - x_out/y_out/colour_out/plot for that pixel are registered and valid in cycle t+2.
- Coordinates:
  - x = x0+col and y = y0+row, computed at 9 bits.
  - If x >= SCR_W or y >= SCR_H, plot=0 for that pixel. Its address is still consumed, so no wrap onto the screen.
  - x_out/y_out carry the low 8/7 bits.
- Clear mode: colour_out forced to 3'b000 regardless of colour_in. addr still counts 0..SCR_W*SCR_H-1.
- FLUSH1, FLUSH2: no new address issued; in-flight pixels drain. After FLUSH2 go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while busy is ignored; inputs are not re-latched.
- abort=1 in DRAW or FLUSHx:
  - Next edge goes to IDLE with busy=0.
  - In-flight pixels are dropped (plot=0 from that edge).
  - No done pulse.
  - abort has no effect in IDLE or DONE.
- Cycle count from start edge to done cycle = width*height + 3.
- mem_sel holds its latched value until the next accepted start.

Decomposition:
- Package blit_pkg: SCR_W, SCR_H, COLOUR_W=3, MEMSEL_W=5, COLOUR_BLACK=3'b000, and the state enum {IDLE, DRAW, FLUSH1, FLUSH2, DONE}.
- Sub-module blit_scan_counter: the col/row/addr counter with wrap and last flag, parameterised on width/height. The top level holds the FSM, the 2-stage valid/coordinate pipeline, and the clip logic.

Test Plan:
- Basic sprite: x0=36, y0=30, sprite_sel=5'd10, start pulse.
  - Expect 1600 plots in consecutive cycles.
  - First plot (36,30) is 2 cycles after addr=0.
  - Last plot (75,69).
  - done in the cycle 1603 after the start edge; mem_sel=10 throughout.
- Clipping: x0=120, y0=90, start.
  - Plots only for x<=159, y<=119: 40x30=1200 plots.
  - addr still reaches 1599; done at cycle 1603.
- Clear mode: clear=1, start, colour_in driven 3'b101.
  - 19200 plots, all colour_out=000.
  - First (0,0), last (159,119); done at cycle 19203.
- Busy ignore and abort:
  - start again mid-draw with x0=0 → no re-latch, coordinates continue.
  - Then abort at addr=500 → plot=0 and busy=0 after the next edge; no done pulse.
- Async reset mid-draw: drop resetn at addr=800.
  - All outputs 0 immediately, without waiting for clk.
  - After release, a new start draws correctly from addr=0.
- Back-to-back: start held high continuously.
  - A second draw begins the cycle after DONE, i.e. in IDLE.
  - Exactly one done per draw, with one idle cycle between draws.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared constants and FSM state type
// for the sprite blitter.
package blit_pkg;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int COLOUR_W = 3;
  localparam int MEMSEL_W = 5;
  localparam logic [COLOUR_W-1:0]
    COLOUR_BLACK = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    FLUSH1,
    FLUSH2,
    DONE
  } blit_state_e;
endpackage

// File: rtl/blit_scan_counter.sv
// Row-major col/row/addr walker with wrap and last flag.
// init zeroes, step advances until last; bounds are runtime inputs.
module blit_scan_counter #(
  parameter int COL_W  = 8,
  parameter int ROW_W  = 7,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              init,
  input  logic              step,
  input  logic [COL_W-1:0]  col_max,
  input  logic [ROW_W-1:0]  row_max,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last = (col_q == col_max) &&
                (row_q == row_max);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (init) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (step && !last) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_q == col_max) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;
endmodule

// File: rtl/sprite_blit_ctrl.sv
// Sprite/clear blitter: FSM, scan counter, 2-stage clip pipeline.
// In: start/clear/abort, x0/y0, sprite_sel, colour_in. Out: VGA strobes.
module sprite_blit_ctrl #(
  parameter int SPR_W  = 40,
  parameter int SPR_H  = 40,
  parameter int SCR_W  = 160,
  parameter int SCR_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        clear,
  input  logic        abort,
  input  logic [7:0]  x0,
  input  logic [6:0]  y0,
  input  logic [blit_pkg::MEMSEL_W-1:0] sprite_sel,
  input  logic [blit_pkg::COLOUR_W-1:0] colour_in,
  output logic [blit_pkg::MEMSEL_W-1:0] mem_sel,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [blit_pkg::COLOUR_W-1:0] colour_out,
  output logic        plot,
  output logic        busy,
  output logic        done
);
  import blit_pkg::*;

  localparam logic [7:0] SPR_CMAX = 8'(SPR_W - 1);
  localparam logic [6:0] SPR_RMAX = 7'(SPR_H - 1);
  localparam logic [7:0] SCR_CMAX = 8'(SCR_W - 1);
  localparam logic [6:0] SCR_RMAX = 7'(SCR_H - 1);
  localparam logic [8:0] X_LIM = 9'(SCR_W);
  localparam logic [8:0] Y_LIM = 9'(SCR_H);

  blit_state_e state_q, state_d;

  logic [7:0] x0_q, x0_d;
  logic [6:0] y0_q, y0_d;
  logic       clr_q, clr_d;
  logic [MEMSEL_W-1:0] mem_sel_q, mem_sel_d;

  logic       vis1_q, vis1_d;
  logic [7:0] x1_q, x1_d;
  logic [6:0] y1_q, y1_d;

  logic       plot_q, plot_d;
  logic [7:0] x_out_q, x_out_d;
  logic [6:0] y_out_q, y_out_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  logic       cnt_init, cnt_step, last;
  logic [7:0] col;
  logic [6:0] row;
  logic [7:0] col_max;
  logic [6:0] row_max;
  logic [8:0] x_sum, y_sum;
  logic       clip, active, kill;

  assign col_max = clr_q ? SCR_CMAX : SPR_CMAX;
  assign row_max = clr_q ? SCR_RMAX : SPR_RMAX;

  blit_scan_counter #(
    .COL_W  (8),
    .ROW_W  (7),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .init    (cnt_init),
    .step    (cnt_step),
    .col_max (col_max),
    .row_max (row_max),
    .col     (col),
    .row     (row),
    .addr    (addr),
    .last    (last)
  );

  assign active = (state_q == DRAW) ||
                  (state_q == FLUSH1) ||
                  (state_q == FLUSH2);
  assign kill = active && abort;

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    clr_d     = clr_q;
    mem_sel_d = mem_sel_q;
    cnt_init  = 1'b0;
    cnt_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRAW;
          cnt_init  = 1'b1;
          x0_d      = clear ? 8'd0 : x0;
          y0_d      = clear ? 7'd0 : y0;
          clr_d     = clear;
          mem_sel_d = sprite_sel;
        end
      end
      DRAW: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_step = 1'b1;
          if (last) state_d = FLUSH1;
        end
      end
      FLUSH1: state_d = abort ? IDLE : FLUSH2;
      FLUSH2: state_d = abort ? IDLE : DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 clips at 9 bits so off-screen pixels never wrap back on.
  always_comb begin
    x_sum  = {1'b0, x0_q} + {1'b0, col};
    y_sum  = {2'b0, y0_q} + {2'b0, row};
    clip   = (x_sum >= X_LIM) || (y_sum >= Y_LIM);
    vis1_d = (state_q == DRAW) && !abort && !clip;
    x1_d   = x_sum[7:0];
    y1_d   = y_sum[6:0];
  end

  // Stage 2 meets colour_in, which lags addr by one cycle.
  always_comb begin
    plot_d   = vis1_q && !kill;
    x_out_d  = plot_d ? x1_q : x_out_q;
    y_out_d  = plot_d ? y1_q : y_out_q;
    colour_d = colour_q;
    if (plot_d) begin
      colour_d = clr_q ? COLOUR_BLACK : colour_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      clr_q     <= 1'b0;
      mem_sel_q <= '0;
      vis1_q    <= 1'b0;
      x1_q      <= '0;
      y1_q      <= '0;
      plot_q    <= 1'b0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      colour_q  <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      clr_q     <= clr_d;
      mem_sel_q <= mem_sel_d;
      vis1_q    <= vis1_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      plot_q    <= plot_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      colour_q  <= colour_d;
    end
  end

  assign mem_sel    = mem_sel_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign busy       = active;
  assign done       = (state_q == DONE);
endmodule
